// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the lapido pipeline controller:
// register-address width, forwarding codes and controller state encodings.
package pipeline_ctrl_pkg;

  localparam int GRP_ADDR_WIDTH = 5;

  localparam logic [1:0] FOWARD_NONE = 2'b00;
  localparam logic [1:0] FOWARD_MEM  = 2'b01;
  localparam logic [1:0] FOWARD_EX   = 2'b10;

  localparam logic [1:0] CTRL_ST_RUN      = 2'd0;
  localparam logic [1:0] CTRL_ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] CTRL_ST_HALT     = 2'd2;

  typedef logic [GRP_ADDR_WIDTH-1:0] addr_t;

  function automatic logic addr_hit(
    input logic  we,
    input addr_t dst,
    input addr_t src
  );
    return we && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_select.sv
// Operand forwarding select for one EX source register.
// The youngest producer (EX/MEM) wins over MEM/WB.
module fwd_select
  import pipeline_ctrl_pkg::*;
(
  input  logic [GRP_ADDR_WIDTH-1:0] src_i,
  input  logic [GRP_ADDR_WIDTH-1:0] exmem_dest_i,
  input  logic                      exmem_we_i,
  input  logic [GRP_ADDR_WIDTH-1:0] memwb_dest_i,
  input  logic                      memwb_we_i,
  output logic [1:0]                sel_o
);

  always_comb begin
    sel_o = FOWARD_NONE;
    if (addr_hit(exmem_we_i, exmem_dest_i, src_i))
      sel_o = FOWARD_EX;
    else if (addr_hit(memwb_we_i, memwb_dest_i, src_i))
      sel_o = FOWARD_MEM;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the lapido 5-stage pipeline:
// forwarding, load-use stalls, branch flushes, memory waits and timeout halt.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GRP_ADDR_WIDTH-1:0] id_rs,
  input  logic [GRP_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic [GRP_ADDR_WIDTH-1:0] idex_dest,
  input  logic                      idex_is_load,
  input  logic                      idex_reg_write,
  input  logic [GRP_ADDR_WIDTH-1:0] ex_rs,
  input  logic [GRP_ADDR_WIDTH-1:0] ex_rt,
  input  logic [GRP_ADDR_WIDTH-1:0] exmem_dest,
  input  logic                      exmem_reg_write,
  input  logic [GRP_ADDR_WIDTH-1:0] memwb_dest,
  input  logic                      memwb_reg_write,
  input  logic                      branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      cnt_clear,
  output logic [1:0]                fowardA,
  output logic [1:0]                fowardB,
  output logic                      pc_write_en,
  output logic                      ifid_write_en,
  output logic                      idex_write_en,
  output logic                      exmem_write_en,
  output logic                      memwb_write_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      idex_bubble,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]           state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 freeze, load_use;
  logic                 br_eff, lu_eff;

  fwd_select u_fwd_a (
    .src_i        (ex_rs),
    .exmem_dest_i (exmem_dest),
    .exmem_we_i   (exmem_reg_write),
    .memwb_dest_i (memwb_dest),
    .memwb_we_i   (memwb_reg_write),
    .sel_o        (fowardA)
  );

  fwd_select u_fwd_b (
    .src_i        (ex_rt),
    .exmem_dest_i (exmem_dest),
    .exmem_we_i   (exmem_reg_write),
    .memwb_dest_i (memwb_dest),
    .memwb_we_i   (memwb_reg_write),
    .sel_o        (fowardB)
  );

  assign freeze =
    ((state_q == CTRL_ST_RUN) && mem_req && !mem_ready) ||
    ((state_q == CTRL_ST_MEM_WAIT) && !mem_ready) ||
    (state_q == CTRL_ST_HALT);

  assign load_use = idex_is_load && idex_reg_write &&
    ((idex_dest == id_rs) || (id_uses_rt && (idex_dest == id_rt)));

  // A branch seen while frozen stays in MEM and flushes once unfrozen.
  assign br_eff = branch_taken && !freeze;
  assign lu_eff = load_use && !freeze && !branch_taken;

  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    idex_write_en  = 1'b1;
    exmem_write_en = 1'b1;
    memwb_write_en = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    idex_bubble    = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_write_en    = 1'b0;
        ifid_write_en  = 1'b0;
        idex_write_en  = 1'b0;
        exmem_write_en = 1'b0;
        memwb_write_en = 1'b0;
      end
      br_eff: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      lu_eff: begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_bubble   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      CTRL_ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = CTRL_ST_MEM_WAIT;
          wait_d  = WW'(1);
        end
      end
      CTRL_ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = CTRL_ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          state_d = CTRL_ST_HALT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      CTRL_ST_HALT: ;
      default: begin
        state_d = CTRL_ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if ((freeze || lu_eff) && (stall_q != '1))
        stall_d = stall_q + CNT_WIDTH'(1);
      if (br_eff && (flush_q != '1))
        flush_d = flush_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_err      = (state_q == CTRL_ST_HALT);
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for forwarding and
// hazard controls, plus sequences for memory wait, timeout and saturation.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_dest, ex_rs, ex_rt;
  logic [4:0] exmem_dest, memwb_dest;
  logic       id_uses_rt, idex_is_load, idex_reg_write;
  logic       exmem_reg_write, memwb_reg_write;
  logic       branch_taken, mem_req, mem_ready, cnt_clear;
  logic [1:0] fowardA, fowardB;
  logic       pc_write_en, ifid_write_en, idex_write_en;
  logic       exmem_write_en, memwb_write_en;
  logic       ifid_flush, idex_flush, idex_bubble, mem_err;
  logic [3:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_dest(idex_dest), .idex_is_load(idex_is_load),
    .idex_reg_write(idex_reg_write),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .exmem_dest(exmem_dest), .exmem_reg_write(exmem_reg_write),
    .memwb_dest(memwb_dest), .memwb_reg_write(memwb_reg_write),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .cnt_clear(cnt_clear),
    .fowardA(fowardA), .fowardB(fowardB),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .idex_write_en(idex_write_en), .exmem_write_en(exmem_write_en),
    .memwb_write_en(memwb_write_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .idex_bubble(idex_bubble), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  wire [4:0] en  = {pc_write_en, ifid_write_en, idex_write_en,
                    exmem_write_en, memwb_write_en};
  wire [2:0] clr = {ifid_flush, idex_flush, idex_bubble};

  typedef struct {
    logic [4:0] ers, ert, exd;
    logic       exw;
    logic [4:0] mwd;
    logic       mww, ld, idw;
    logic [4:0] idd, rs, rt;
    logic       urt, br;
    logic [1:0] fa, fb;
    logic [4:0] en;
    logic [2:0] clr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; idex_dest = 0;
    idex_is_load = 0; idex_reg_write = 0; ex_rs = 0; ex_rt = 0;
    exmem_dest = 0; exmem_reg_write = 0;
    memwb_dest = 0; memwb_reg_write = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clear = 0;
  endtask

  int exp_st, exp_fl;

  initial begin
    //         ers ert exd w mwd w ld iw idd rs rt u br fa fb en clr
    vecs[0]  = '{3, 7, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,
                 FOWARD_EX, FOWARD_NONE, 5'b11111, 3'b000};
    vecs[1]  = '{3, 7, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0,
                 FOWARD_MEM, FOWARD_NONE, 5'b11111, 3'b000};
    vecs[2]  = '{3, 7, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0,
                 FOWARD_NONE, FOWARD_NONE, 5'b11111, 3'b000};
    vecs[3]  = '{4, 9, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,
                 FOWARD_NONE, FOWARD_EX, 5'b11111, 3'b000};
    vecs[4]  = '{6, 6, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,
                 FOWARD_MEM, FOWARD_MEM, 5'b11111, 3'b000};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 5, 1, 0,
                 FOWARD_NONE, FOWARD_NONE, 5'b00111, 3'b001};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 5, 0, 0,
                 FOWARD_NONE, FOWARD_NONE, 5'b11111, 3'b000};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 5, 2, 0, 0,
                 FOWARD_NONE, FOWARD_NONE, 5'b00111, 3'b001};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 5, 5, 5, 1, 0,
                 FOWARD_NONE, FOWARD_NONE, 5'b11111, 3'b000};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 5, 1, 0,
                 FOWARD_NONE, FOWARD_NONE, 5'b11111, 3'b000};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 5, 1, 1,
                 FOWARD_NONE, FOWARD_NONE, 5'b11111, 3'b110};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 FOWARD_NONE, FOWARD_NONE, 5'b11111, 3'b110};

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_en", en, 5'b11111);
    chk("rst_clr", clr, 3'b000);
    chk("rst_err", mem_err, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_flush", flush_count, 0);

    exp_st = 0;
    exp_fl = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ex_rs = vecs[i].ers; ex_rt = vecs[i].ert;
      exmem_dest = vecs[i].exd; exmem_reg_write = vecs[i].exw;
      memwb_dest = vecs[i].mwd; memwb_reg_write = vecs[i].mww;
      idex_is_load = vecs[i].ld; idex_reg_write = vecs[i].idw;
      idex_dest = vecs[i].idd; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rt = vecs[i].urt; branch_taken = vecs[i].br;
      #1;
      chk($sformatf("v%0d_fwdA", i), fowardA, vecs[i].fa);
      chk($sformatf("v%0d_fwdB", i), fowardB, vecs[i].fb);
      chk($sformatf("v%0d_en", i), en, vecs[i].en);
      chk($sformatf("v%0d_clr", i), clr, vecs[i].clr);
      exp_st += int'(vecs[i].clr[0]);
      exp_fl += int'(vecs[i].clr[1]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_stall", i), stall_cycles, exp_st);
      chk($sformatf("v%0d_flush", i), flush_count, exp_fl);
    end

    // Memory wait with a branch held in MEM across the stall.
    @(negedge clk);
    idle();
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_stall", stall_cycles, 0);
    chk("clr_flush", flush_count, 0);
    @(negedge clk);
    cnt_clear = 1'b0;
    mem_req = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("mw%0d_en", c), en, 5'b00000);
      chk($sformatf("mw%0d_clr", c), clr, 3'b000);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("mw_ready_en", en, 5'b11111);
    chk("mw_ready_clr", clr, 3'b110);
    @(posedge clk);
    #1;
    chk("mw_stall", stall_cycles, 3);
    chk("mw_flush", flush_count, 1);
    @(negedge clk);
    idle();
    #1;
    chk("mw_run_en", en, 5'b11111);

    // Ready arriving in the 4th cycle keeps the core running.
    @(negedge clk);
    mem_req = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("late_ready_err", mem_err, 0);
    chk("late_ready_en", en, 5'b11111);

    // Four consecutive stalled cycles halt the core.
    @(negedge clk);
    mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("pre_halt%0d_err", k), mem_err, 0);
      chk($sformatf("pre_halt%0d_en", k), en, 5'b00000);
      @(negedge clk);
    end
    #1;
    chk("halt_err", mem_err, 1);
    mem_req = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("halt_hold_en", en, 5'b00000);
    chk("halt_hold_err", mem_err, 1);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", stall_cycles, 15);
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_clear", stall_cycles, 0);
    @(negedge clk);
    cnt_clear = 1'b0;

    // Asynchronous reset out of HALT, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err", mem_err, 0);
    chk("arst_stall", stall_cycles, 0);
    chk("arst_flush", flush_count, 0);
    chk("arst_en", en, 5'b11111);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_en", en, 5'b11111);
    chk("post_rst_stall", stall_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the lapido 5-stage pipeline. It produces the EX-stage operand forwarding selects and the per-stage write-enable, flush and bubble controls. It also resolves load-use hazards, branch flushes and data-memory wait states, and halts the core on a memory timeout. It sits beside the datapath and drives the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.

## Interface
- `MEM_TIMEOUT`, default 16: number of consecutive memory-stall cycles after which the core halts (minimum 2).
- `CNT_WIDTH`, default 16: width of the performance counters.

Ports (all addresses are `GRP_ADDR_WIDTH` wide):
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `id_rs`, `id_rt`  in  addr  source fields of the instruction in ID
- `id_uses_rt`  in  1  the instruction in ID reads rt
- `idex_dest`  in  addr  destination of the instruction in ID/EX
- `idex_is_load`, `idex_reg_write`  in  1  ID/EX control bits
- `ex_rs`, `ex_rt`  in  addr  source fields of the instruction in EX
- `exmem_dest`, `exmem_reg_write`  in  addr/1  EX/MEM destination and write enable
- `memwb_dest`, `memwb_reg_write`  in  addr/1  MEM/WB destination and write enable
- `branch_taken`  in  1  branch resolved taken in MEM
- `mem_req`  in  1  the instruction in MEM accesses data memory
- `mem_ready`  in  1  data memory completes the access this cycle
- `cnt_clear`  in  1  synchronous clear of both counters
- `fowardA`, `fowardB`  out  2  forwarding selects (`FOWARD_EX`, `FOWARD_MEM` or `FOWARD_NONE`)
- `pc_write_en`, `ifid_write_en`, `idex_write_en`, `exmem_write_en`, `memwb_write_en`  out  1  stage-register enables
- `ifid_flush`, `idex_flush`, `idex_bubble`  out  1  clear controls for the stage registers
- `mem_err`  out  1  high while in HALT
- `stall_cycles`, `flush_count`  out  `CNT_WIDTH`  saturating performance counters

## Operation
- **Forwarding.** For each of rs and rt:
  - Select `FOWARD_EX` if `exmem_reg_write` is high and `exmem_dest` matches.
  - Otherwise select `FOWARD_MEM` if `memwb_reg_write` is high and `memwb_dest` matches.
  - Otherwise select `FOWARD_NONE`. EX has priority over MEM.
  - Forwarding is independent of the FSM state.
- **FSM states:** RUN, MEM_WAIT, HALT.
  - RUN → MEM_WAIT when `mem_req` is high and `mem_ready` is low. The wait counter is set to 1.
  - MEM_WAIT → RUN when `mem_ready` is high.
  - MEM_WAIT, with `mem_ready` low: increment the wait counter. When the counter equals `MEM_TIMEOUT`, go to HALT.
  - HALT → only `rst` exits.
- **`freeze`** is high in any of these cases:
  - state is RUN, `mem_req` is high and `mem_ready` is low;
  - state is MEM_WAIT and `mem_ready` is low;
  - state is HALT.
- **`load_use`** = `idex_is_load` AND `idex_reg_write` AND (`idex_dest` == `id_rs` OR (`id_uses_rt` AND `idex_dest` == `id_rt`)).
- **Control priority**, highest first. By default all enables are 1 and all clears are 0.
  1. **`freeze`:** all five enables are 0 and no flush or bubble is asserted. Re-holding MEM/WB is idempotent.
  2. **`branch_taken`:** `ifid_flush` = 1 and `idex_flush` = 1. `pc_write_en` = 1 so the PC loads the target. `load_use` is ignored.
  3. **`load_use`:** `pc_write_en` = 0, `ifid_write_en` = 0, `idex_bubble` = 1.
- **`branch_taken` under `freeze`:** the branch is held in MEM and flushes in the first unfrozen cycle.
- **`stall_cycles`** increments on every cycle in which `freeze` or an effective `load_use` is asserted.
- **`flush_count`** increments on every effective branch flush.
- **Counters:** both saturate at all-ones. `cnt_clear` has priority over increment.

## Timing
- Forwarding selects and all control outputs are combinational from the inputs and current state: zero latency.
- The state, wait counter and performance counters update on the rising edge of `clk`.
- **Reset:** state = RUN, wait counter = 0, `stall_cycles` = 0, `flush_count` = 0, `mem_err` = 0. With idle inputs after reset, all enables are 1 and all flush/bubble outputs are 0.
- **Memory stall:** the first stalled cycle is the cycle in which `mem_req` is high and `mem_ready` is low. The pipeline advances at the end of the cycle in which `mem_ready` is high.
- **Timeout:** HALT is entered at the edge that ends the `MEM_TIMEOUT`-th consecutive stalled cycle. A `mem_ready` in that same cycle takes priority and the FSM returns to RUN.
- **Reset mid-stall:** HALT or MEM_WAIT returns to RUN immediately, and the counters clear.

## Structure
- Add to `lapido_defs.v`: state encodings `CTRL_ST_RUN`, `CTRL_ST_MEM_WAIT`, `CTRL_ST_HALT`. Reuse the existing `FOWARD_EX`, `FOWARD_MEM` and `FOWARD_NONE` codes and `GRP_ADDR_WIDTH`.
- One combinational sub-module, `fwd_select`, instantiated twice (once for rs, once for rt). It takes a source address plus the EX/MEM and MEM/WB destination/write pairs and returns a 2-bit select.

## Test plan
- **Forwarding priority:** `ex_rs` = 3, `exmem_dest` = 3 (write on), `memwb_dest` = 3 (write on) → `fowardA` = `FOWARD_EX`. Then clear `exmem_reg_write` → `FOWARD_MEM`. Then clear `memwb_reg_write` → `FOWARD_NONE`.
- **Load-use:** `idex_is_load` = 1, `idex_dest` = 5, `id_rt` = 5, `id_uses_rt` = 1 → for one cycle `pc_write_en` = 0, `ifid_write_en` = 0, `idex_bubble` = 1. `stall_cycles` goes 0 → 1. With `id_uses_rt` = 0 → no stall.
- **Branch beats load-use:** `branch_taken` and `load_use` in the same cycle → `ifid_flush` = 1, `idex_flush` = 1, `pc_write_en` = 1, `idex_bubble` = 0. `flush_count` = 1.
- **Memory wait:** `mem_req` = 1 with `mem_ready` low for 3 cycles, then high → all enables 0 for 3 cycles, state returns to RUN, `stall_cycles` = 3.
- **Timeout:** `MEM_TIMEOUT` = 4, `mem_ready` held low → HALT after 4 stalled cycles, `mem_err` = 1 and all enables stay 0. Assert `rst` → RUN, `mem_err` = 0, counters = 0.
- **Saturation and clear:** `CNT_WIDTH` = 4, hold `freeze` for 20 cycles → `stall_cycles` = 15. Pulse `cnt_clear` → 0 on the next edge.
